// File: rtl/fmul_iter.sv
// Iterative single-precision multiplier: shift-and-add mantissa core, one bit per cycle,
// fed by pre-decoded operand fields and returning a packed IEEE-754 product.
module fmul_iter #(
    parameter int EXPW  = 8,
    parameter int MANW  = 23,
    parameter int DATAW = 32,
    parameter int BIAS  = 127
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_sign,
    input  logic             b_sign,
    input  logic [EXPW-1:0]  a_exp,
    input  logic [EXPW-1:0]  b_exp,
    input  logic [MANW:0]    a_man,
    input  logic [MANW:0]    b_man,
    input  logic             a_nan,
    input  logic             b_nan,
    input  logic             a_inf,
    input  logic             b_inf,
    input  logic             a_zero,
    input  logic             b_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] result
);

    localparam int FW   = MANW + 1;
    localparam int PW   = 2 * FW;
    localparam int EW   = EXPW + 2;
    localparam int CNTW = $clog2(FW);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXPW) - 1);

    typedef enum logic [1:0] {StIdle, StMul, StPack, StDone} state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATAW-1:0]      r_result;
    logic                  r_sign;
    logic [EXPW-1:0]       r_a_exp;
    logic [EXPW-1:0]       r_b_exp;
    logic signed [EW-1:0]  r_e;
    logic [PW-1:0]         r_mcand;
    logic [FW-1:0]         r_mplier;
    logic [PW-1:0]         r_acc;
    logic [CNTW-1:0]       r_cnt;

    logic                  w_a_zero;
    logic                  w_b_zero;
    logic                  w_sign;
    logic                  w_spec_nan;
    logic                  w_spec_inf;
    logic                  w_special;
    logic [DATAW-1:0]      w_spec_res;
    logic signed [EW-1:0]  w_e_sum;
    logic                  w_msb;
    logic [PW-1:0]         w_norm;
    logic [FW-1:0]         w_man;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_inc;
    logic [FW:0]           w_rnd;
    logic                  w_carry;
    logic [MANW-1:0]       w_frac;
    logic signed [EW-1:0]  w_e_adj;
    logic signed [EW-1:0]  w_e_fin;
    logic                  w_ovf;
    logic                  w_unf;
    logic [DATAW-1:0]      w_pack_res;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    // Zero exponent means zero or denormal; both are treated as zero.
    assign w_a_zero   = a_zero | (a_exp == '0);
    assign w_b_zero   = b_zero | (b_exp == '0);
    assign w_sign     = a_sign ^ b_sign;
    assign w_spec_nan = a_nan | b_nan | (a_inf & w_b_zero) | (b_inf & w_a_zero);
    assign w_spec_inf = a_inf | b_inf;
    assign w_special  = w_spec_nan | w_spec_inf | w_a_zero | w_b_zero;

    always_comb begin
        w_spec_res = {w_sign, {(DATAW-1){1'b0}}};
        if (w_spec_nan) begin
            w_spec_res = {1'b0, {EXPW{1'b1}}, 1'b1, {(MANW-1){1'b0}}};
        end else if (w_spec_inf) begin
            w_spec_res = {w_sign, {EXPW{1'b1}}, {MANW{1'b0}}};
        end
    end

    assign w_e_sum = $signed({2'b00, r_a_exp}) + $signed({2'b00, r_b_exp}) - $signed(EW'(BIAS));

    // Normalise so the leading one sits at the product MSB, then round to nearest even.
    assign w_msb    = r_acc[PW-1];
    assign w_norm   = w_msb ? r_acc : (r_acc << 1);
    assign w_man    = w_norm[PW-1 -: FW];
    assign w_guard  = w_norm[MANW];
    assign w_sticky = |w_norm[MANW-1:0];
    assign w_inc    = w_guard & (w_sticky | w_man[0]);
    assign w_rnd    = {1'b0, w_man} + {{FW{1'b0}}, w_inc};
    assign w_carry  = w_rnd[FW];
    assign w_frac   = w_carry ? w_rnd[MANW:1] : w_rnd[MANW-1:0];
    assign w_e_adj  = {{EXPW{1'b0}}, w_msb & w_carry, w_msb ^ w_carry};
    assign w_e_fin  = r_e + w_e_adj;
    assign w_ovf    = (w_e_fin >= EMAX);
    assign w_unf    = w_e_fin[EW-1] | (w_e_fin == '0);

    always_comb begin
        w_pack_res = {r_sign, w_e_fin[EXPW-1:0], w_frac};
        if (w_ovf) begin
            w_pack_res = {r_sign, {EXPW{1'b1}}, {MANW{1'b0}}};
        end else if (w_unf) begin
            w_pack_res = {r_sign, {(DATAW-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_sign      <= 1'b0;
            r_a_exp     <= '0;
            r_b_exp     <= '0;
            r_e         <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        r_sign     <= w_sign;
                        if (w_special) begin
                            r_result    <= w_spec_res;
                            r_out_valid <= 1'b1;
                            r_state     <= StDone;
                        end else begin
                            r_a_exp  <= a_exp;
                            r_b_exp  <= b_exp;
                            r_mcand  <= {{FW{1'b0}}, a_man};
                            r_mplier <= b_man;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_state  <= StMul;
                        end
                    end
                end
                StMul: begin
                    if (r_cnt == '0) begin
                        r_e <= w_e_sum;
                    end
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNTW'(MANW)) begin
                        r_state <= StPack;
                    end
                end
                StPack: begin
                    r_result    <= w_pack_res;
                    r_out_valid <= 1'b1;
                    r_state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_iter.sv
// Bench for fmul_iter: vector table through a result scoreboard, plus backpressure and
// mid-operation reset sequences.
module tb_fmul_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic [23:0] a_man, b_man;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int          total = 0;
    int          bad = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    fmul_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sign    (a_sign),
        .b_sign    (b_sign),
        .a_exp     (a_exp),
        .b_exp     (b_exp),
        .a_man     (a_man),
        .b_man     (b_man),
        .a_nan     (a_nan),
        .b_nan     (b_nan),
        .a_inf     (a_inf),
        .b_inf     (b_inf),
        .a_zero    (a_zero),
        .b_zero    (b_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, req);
        end
    endtask

    // Emulates the upstream field decoder.
    task automatic drive_ops(input logic [31:0] a, input logic [31:0] b);
        a_sign = a[31];
        a_exp  = a[30:23];
        a_man  = {(a[30:23] != 8'd0), a[22:0]};
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'd0) && (a[22:0] == 23'd0);
        b_sign = b[31];
        b_exp  = b[30:23];
        b_man  = {(b[30:23] != 8'd0), b[22:0]};
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        b_zero = (b[30:23] == 8'd0) && (b[22:0] == 23'd0);
    endtask

    task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expected);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL %s in_ready timeout: got 0 want 1", name);
        end
        drive_ops(a, b);
        in_valid = 1'b1;
        sb_q.push_back(expected);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, output int lat, output logic saw_ready);
        lat = 1;
        saw_ready = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            total++;
            bad++;
            $display("FAIL %s out_valid timeout: got 0 want 1", name);
        end
    endtask

    // Pops the scoreboard against the presented result; out_ready must already be 1.
    task automatic take_result(input string name);
        logic [31:0] req;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty: got %08h want none", name, result);
        end else begin
            req = sb_q.pop_front();
            check({name, " result"}, result, req);
        end
        @(posedge clk);
        #1;
        check({name, " after handshake {out_valid,in_ready}"}, {30'd0, out_valid, in_ready},
              32'd1);
    endtask

    initial begin
        int          lat;
        logic        saw;
        logic [31:0] held;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 26};
        vecs[1]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1};
        vecs[2]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1};
        vecs[3]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1};
        vecs[4]  = '{32'h00000001, 32'h40400000, 32'h00000000, 1};
        vecs[5]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 26};
        vecs[6]  = '{32'h8C800000, 32'h0C800000, 32'h80000000, 26};
        vecs[7]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 26};
        vecs[8]  = '{32'h3F800800, 32'h3F800800, 32'h3F801000, 26};
        vecs[9]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 26};
        vecs[10] = '{32'h3FC00001, 32'h3FC00001, 32'h40100002, 26};
        vecs[11] = '{32'h40000000, 32'hC0400000, 32'hC0C00000, 26};
        vecs[12] = '{32'h00000000, 32'hC0A00000, 32'h80000000, 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive_ops(32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("in reset {out_valid,in_ready}", {30'd0, out_valid, in_ready}, 32'd1);
        check("in reset result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after reset {out_valid,in_ready}", {30'd0, out_valid, in_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            issue(nm, vecs[i].a, vecs[i].b, vecs[i].res);
            wait_valid(nm, lat, saw);
            check({nm, " latency"}, lat, vecs[i].lat);
            check({nm, " in_ready busy"}, {31'd0, saw}, 32'd0);
            take_result(nm);
        end

        // Backpressure: result held, extra in_valid ignored while DONE.
        out_ready = 1'b0;
        issue("bp", 32'h3FC00000, 32'h40000000, 32'h40400000);
        wait_valid("bp", lat, saw);
        check("bp latency", lat, 26);
        held = result;
        drive_ops(32'h40000000, 32'h40000000);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d {out_valid,in_ready}", i),
                  {30'd0, out_valid, in_ready}, 32'd2);
            check($sformatf("bp hold%0d result", i), result, held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        take_result("bp");
        issue("bp2", 32'h3FC00001, 32'h3FC00001, 32'h40100002);
        wait_valid("bp2", lat, saw);
        check("bp2 latency", lat, 26);
        take_result("bp2");

        // Reset during MUL aborts the operation.
        issue("rstmul", 32'h3FC00000, 32'h40000000, 32'h40400000);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        check("rstmul async {out_valid,in_ready}", {30'd0, out_valid, in_ready}, 32'd1);
        check("rstmul async result", result, 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        issue("post_rst", 32'h3FC00000, 32'h40000000, 32'h40400000);
        wait_valid("post_rst", lat, saw);
        check("post_rst latency", lat, 26);
        take_result("post_rst");

        check("scoreboard drained", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
